// File: rtl/control_fsm.sv
// Multicycle processor control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback steps; every control output is forced low while Reset is high.
module control_fsm (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [15:0] input_instruction,
    input  logic        input_mem_ready,
    input  logic        input_zero,
    output logic        output_PCWrite,
    output logic        output_PCWriteCond,
    output logic        output_IorD,
    output logic        output_MemRead,
    output logic        output_MemWrite,
    output logic        output_IRWrite,
    output logic        output_reg_write,
    output logic        output_memToReg,
    output logic [2:0]  output_reg_readA_address,
    output logic [2:0]  output_reg_readB_address,
    output logic [2:0]  output_reg_write_address,
    output logic        output_ALUSrcA,
    output logic [1:0]  output_ALUSrcB,
    output logic [2:0]  output_ALUOp,
    output logic [1:0]  output_PCSource,
    output logic [3:0]  output_state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        EXEC_LUI  = 4'd4,
        MEM_ADDR  = 4'd5,
        MEM_READ  = 4'd6,
        MEM_WRITE = 4'd7,
        WB_ALU    = 4'd8,
        WB_MEM    = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    state_t     state_q, state_d;
    logic [3:0] opcode;

    assign opcode = input_instruction[15:12];

    // The zero flag is consumed outside this block; the low instruction bits carry no fields here.
    logic unused_inputs;
    assign unused_inputs = ^{input_zero, input_instruction[2:0]};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:     state_d = input_mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011: state_d = EXEC_R;
                    4'b0100:                            state_d = EXEC_I;
                    4'b0101:                            state_d = EXEC_LUI;
                    4'b0110, 4'b0111:                   state_d = MEM_ADDR;
                    4'b1000:                            state_d = BRANCH;
                    4'b1001:                            state_d = JUMP;
                    default:                            state_d = FETCH;
                endcase
            end
            EXEC_R, EXEC_I, EXEC_LUI: state_d = WB_ALU;
            MEM_ADDR:  state_d = (opcode == 4'b0111) ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_d = input_mem_ready ? WB_MEM : MEM_READ;
            MEM_WRITE: state_d = input_mem_ready ? FETCH : MEM_WRITE;
            WB_ALU, WB_MEM, BRANCH, JUMP: state_d = FETCH;
            default:   state_d = FETCH;
        endcase
    end

    // Outputs depend on state only (plus mem_ready in FETCH); Reset overrides everything.
    always_comb begin
        output_PCWrite           = 1'b0;
        output_PCWriteCond       = 1'b0;
        output_IorD              = 1'b0;
        output_MemRead           = 1'b0;
        output_MemWrite          = 1'b0;
        output_IRWrite           = 1'b0;
        output_reg_write         = 1'b0;
        output_memToReg          = 1'b0;
        output_ALUSrcA           = 1'b0;
        output_ALUSrcB           = 2'b00;
        output_ALUOp             = ALU_ADD;
        output_PCSource          = 2'b00;
        output_reg_readA_address = input_instruction[8:6];
        output_reg_readB_address = input_instruction[5:3];
        output_reg_write_address = input_instruction[11:9];
        output_state             = state_q;
        case (state_q)
            FETCH: begin
                output_MemRead = 1'b1;
                output_ALUSrcB = 2'b01;
                output_IRWrite = input_mem_ready;
                output_PCWrite = input_mem_ready;
            end
            DECODE: output_ALUSrcB = 2'b10;
            EXEC_R: begin
                output_ALUSrcA = 1'b1;
                output_ALUOp   = {1'b0, opcode[1:0]};
            end
            EXEC_I, MEM_ADDR: begin
                output_ALUSrcA = 1'b1;
                output_ALUSrcB = 2'b10;
            end
            EXEC_LUI: begin
                output_ALUSrcB = 2'b10;
                output_ALUOp   = ALU_PASSB;
            end
            WB_ALU: output_reg_write = 1'b1;
            MEM_READ: begin
                output_MemRead = 1'b1;
                output_IorD    = 1'b1;
            end
            MEM_WRITE: begin
                output_MemWrite = 1'b1;
                output_IorD     = 1'b1;
            end
            WB_MEM: begin
                output_reg_write = 1'b1;
                output_memToReg  = 1'b1;
            end
            BRANCH: begin
                output_ALUSrcA     = 1'b1;
                output_ALUOp       = ALU_SUB;
                output_PCWriteCond = 1'b1;
                output_PCSource    = 2'b01;
            end
            JUMP: begin
                output_PCWrite  = 1'b1;
                output_PCSource = 2'b10;
            end
            default: ;
        endcase
        if (Reset) begin
            output_PCWrite           = 1'b0;
            output_PCWriteCond       = 1'b0;
            output_IorD              = 1'b0;
            output_MemRead           = 1'b0;
            output_MemWrite          = 1'b0;
            output_IRWrite           = 1'b0;
            output_reg_write         = 1'b0;
            output_memToReg          = 1'b0;
            output_ALUSrcA           = 1'b0;
            output_ALUSrcB           = 2'b00;
            output_ALUOp             = 3'b000;
            output_PCSource          = 2'b00;
            output_reg_readA_address = 3'b000;
            output_reg_readB_address = 3'b000;
            output_reg_write_address = 3'b000;
            output_state             = 4'd0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: walks each instruction class through its
// state sequence and compares the packed control word against hand-built constants.
module tb_control_fsm;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] input_instruction;
    logic        input_mem_ready;
    logic        input_zero;
    logic        output_PCWrite, output_PCWriteCond, output_IorD, output_MemRead;
    logic        output_MemWrite, output_IRWrite, output_reg_write, output_memToReg;
    logic [2:0]  output_reg_readA_address, output_reg_readB_address, output_reg_write_address;
    logic        output_ALUSrcA;
    logic [1:0]  output_ALUSrcB;
    logic [2:0]  output_ALUOp;
    logic [1:0]  output_PCSource;
    logic [3:0]  output_state;

    int checks = 0;
    int passes = 0;

    // Packed as PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,reg_write,memToReg,SrcA,SrcB,ALUOp,PCSource
    logic [15:0] ctrl;
    logic [8:0]  addrs;
    assign ctrl = {output_PCWrite, output_PCWriteCond, output_IorD, output_MemRead,
                   output_MemWrite, output_IRWrite, output_reg_write, output_memToReg,
                   output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCSource};
    assign addrs = {output_reg_write_address, output_reg_readA_address, output_reg_readB_address};

    localparam logic [15:0] C_ZERO       = 16'b0_0_0_0_0_0_0_0_0_00_000_00;
    localparam logic [15:0] C_FETCH      = 16'b1_0_0_1_0_1_0_0_0_01_000_00;
    localparam logic [15:0] C_FETCH_WAIT = 16'b0_0_0_1_0_0_0_0_0_01_000_00;
    localparam logic [15:0] C_DECODE     = 16'b0_0_0_0_0_0_0_0_0_10_000_00;
    localparam logic [15:0] C_EXEC_ADD   = 16'b0_0_0_0_0_0_0_0_1_00_000_00;
    localparam logic [15:0] C_EXEC_SUB   = 16'b0_0_0_0_0_0_0_0_1_00_001_00;
    localparam logic [15:0] C_EXEC_AND   = 16'b0_0_0_0_0_0_0_0_1_00_010_00;
    localparam logic [15:0] C_EXEC_OR    = 16'b0_0_0_0_0_0_0_0_1_00_011_00;
    localparam logic [15:0] C_EXEC_I     = 16'b0_0_0_0_0_0_0_0_1_10_000_00;
    localparam logic [15:0] C_LUI        = 16'b0_0_0_0_0_0_0_0_0_10_100_00;
    localparam logic [15:0] C_WB_ALU     = 16'b0_0_0_0_0_0_1_0_0_00_000_00;
    localparam logic [15:0] C_MEM_ADDR   = 16'b0_0_0_0_0_0_0_0_1_10_000_00;
    localparam logic [15:0] C_MEM_READ   = 16'b0_0_1_1_0_0_0_0_0_00_000_00;
    localparam logic [15:0] C_MEM_WRITE  = 16'b0_0_1_0_1_0_0_0_0_00_000_00;
    localparam logic [15:0] C_WB_MEM     = 16'b0_0_0_0_0_0_1_1_0_00_000_00;
    localparam logic [15:0] C_BRANCH     = 16'b0_1_0_0_0_0_0_0_1_00_001_01;
    localparam logic [15:0] C_JUMP       = 16'b1_0_0_0_0_0_0_0_0_00_000_10;

    control_fsm dut (
        .CLK                      (CLK),
        .Reset                    (Reset),
        .input_instruction        (input_instruction),
        .input_mem_ready          (input_mem_ready),
        .input_zero               (input_zero),
        .output_PCWrite           (output_PCWrite),
        .output_PCWriteCond       (output_PCWriteCond),
        .output_IorD              (output_IorD),
        .output_MemRead           (output_MemRead),
        .output_MemWrite          (output_MemWrite),
        .output_IRWrite           (output_IRWrite),
        .output_reg_write         (output_reg_write),
        .output_memToReg          (output_memToReg),
        .output_reg_readA_address (output_reg_readA_address),
        .output_reg_readB_address (output_reg_readB_address),
        .output_reg_write_address (output_reg_write_address),
        .output_ALUSrcA           (output_ALUSrcA),
        .output_ALUSrcB           (output_ALUSrcB),
        .output_ALUOp             (output_ALUOp),
        .output_PCSource          (output_PCSource),
        .output_state             (output_state)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        Reset = 1'b1;
        input_instruction = 16'h0298;
        input_mem_ready = 1'b1;
        input_zero = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL reset_state: got %0d expected 0", output_state); else passes++;
        checks++; if (ctrl !== C_ZERO) $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_ZERO); else passes++;
        checks++; if (addrs !== 9'd0) $display("[TB] FAIL reset_addrs: got %b expected %b", addrs, 9'd0); else passes++;
        Reset = 1'b0;
        #1;
        checks++; if (ctrl !== C_FETCH) $display("[TB] FAIL release_fetch_ctrl: got %b expected %b", ctrl, C_FETCH); else passes++;
    endtask

    task automatic test_add();
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL add_s0: got %0d expected 0", output_state); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd1) $display("[TB] FAIL add_s1: got %0d expected 1", output_state); else passes++;
        checks++; if (ctrl !== C_DECODE) $display("[TB] FAIL add_decode_ctrl: got %b expected %b", ctrl, C_DECODE); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd2) $display("[TB] FAIL add_s2: got %0d expected 2", output_state); else passes++;
        checks++; if (ctrl !== C_EXEC_ADD) $display("[TB] FAIL add_exec_ctrl: got %b expected %b", ctrl, C_EXEC_ADD); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd8) $display("[TB] FAIL add_s8: got %0d expected 8", output_state); else passes++;
        checks++; if (ctrl !== C_WB_ALU) $display("[TB] FAIL add_wb_ctrl: got %b expected %b", ctrl, C_WB_ALU); else passes++;
        checks++; if (addrs !== {3'd1, 3'd2, 3'd3}) $display("[TB] FAIL add_addrs: got %b expected %b", addrs, {3'd1, 3'd2, 3'd3}); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL add_back_fetch: got %0d expected 0", output_state); else passes++;
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops     [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        logic [3:0]  expSt   [5] = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd4};
        logic [15:0] expCtrl [5] = '{C_EXEC_SUB, C_EXEC_AND, C_EXEC_OR, C_EXEC_I, C_LUI};
        for (int i = 0; i < 5; i++) begin
            input_instruction = {ops[i], 12'h298};
            repeat (2) @(negedge CLK);
            checks++; if (output_state !== expSt[i]) $display("[TB] FAIL alu_state op%0h: got %0d expected %0d", ops[i], output_state, expSt[i]); else passes++;
            checks++; if (ctrl !== expCtrl[i]) $display("[TB] FAIL alu_ctrl op%0h: got %b expected %b", ops[i], ctrl, expCtrl[i]); else passes++;
            @(negedge CLK);
            checks++; if (output_state !== 4'd8) $display("[TB] FAIL alu_wb op%0h: got %0d expected 8", ops[i], output_state); else passes++;
            @(negedge CLK);
        end
    endtask

    task automatic test_lw_wait();
        input_instruction = 16'h6280;
        repeat (2) @(negedge CLK);
        checks++; if (output_state !== 4'd5) $display("[TB] FAIL lw_addr_state: got %0d expected 5", output_state); else passes++;
        checks++; if (ctrl !== C_MEM_ADDR) $display("[TB] FAIL lw_addr_ctrl: got %b expected %b", ctrl, C_MEM_ADDR); else passes++;
        input_mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (c == 2) input_mem_ready = 1'b1;
            checks++; if (output_state !== 4'd6) $display("[TB] FAIL lw_read_state c%0d: got %0d expected 6", c, output_state); else passes++;
            checks++; if (ctrl !== C_MEM_READ) $display("[TB] FAIL lw_read_ctrl c%0d: got %b expected %b", c, ctrl, C_MEM_READ); else passes++;
        end
        @(negedge CLK);
        checks++; if (output_state !== 4'd9) $display("[TB] FAIL lw_wbmem_state: got %0d expected 9", output_state); else passes++;
        checks++; if (ctrl !== C_WB_MEM) $display("[TB] FAIL lw_wbmem_ctrl: got %b expected %b", ctrl, C_WB_MEM); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL lw_back_fetch: got %0d expected 0", output_state); else passes++;
    endtask

    task automatic test_beq();
        input_instruction = 16'h8098;
        input_zero = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (output_state !== 4'd10) $display("[TB] FAIL beq_state: got %0d expected 10", output_state); else passes++;
        checks++; if (ctrl !== C_BRANCH) $display("[TB] FAIL beq_ctrl: got %b expected %b", ctrl, C_BRANCH); else passes++;
        @(negedge CLK);
        input_zero = 1'b0;
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL beq_back_fetch: got %0d expected 0", output_state); else passes++;
    endtask

    task automatic test_illegal();
        input_instruction = 16'hF000;
        @(negedge CLK);
        checks++; if (ctrl !== C_DECODE) $display("[TB] FAIL illegal_decode_ctrl: got %b expected %b", ctrl, C_DECODE); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL illegal_back_fetch: got %0d expected 0", output_state); else passes++;
    endtask

    task automatic test_fetch_wait_jump();
        input_instruction = 16'h9000;
        input_mem_ready = 1'b0;
        #1;
        checks++; if (ctrl !== C_FETCH_WAIT) $display("[TB] FAIL fetch_wait_ctrl: got %b expected %b", ctrl, C_FETCH_WAIT); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL fetch_wait_hold: got %0d expected 0", output_state); else passes++;
        input_mem_ready = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (output_state !== 4'd11) $display("[TB] FAIL jump_state: got %0d expected 11", output_state); else passes++;
        checks++; if (ctrl !== C_JUMP) $display("[TB] FAIL jump_ctrl: got %b expected %b", ctrl, C_JUMP); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL jump_back_fetch: got %0d expected 0", output_state); else passes++;
    endtask

    task automatic test_sw_reset();
        input_instruction = 16'h7280;
        repeat (2) @(negedge CLK);
        input_mem_ready = 1'b0;
        @(negedge CLK);
        checks++; if (output_state !== 4'd7) $display("[TB] FAIL sw_state: got %0d expected 7", output_state); else passes++;
        checks++; if (ctrl !== C_MEM_WRITE) $display("[TB] FAIL sw_ctrl: got %b expected %b", ctrl, C_MEM_WRITE); else passes++;
        @(negedge CLK);
        checks++; if (output_state !== 4'd7) $display("[TB] FAIL sw_hold: got %0d expected 7", output_state); else passes++;
        Reset = 1'b1;
        #1;
        checks++; if (output_MemWrite !== 1'b0) $display("[TB] FAIL sw_abort_memwrite: got %b expected 0", output_MemWrite); else passes++;
        checks++; if (output_state !== 4'd0) $display("[TB] FAIL sw_abort_state: got %0d expected 0", output_state); else passes++;
        input_mem_ready = 1'b1;
        @(negedge CLK);
        checks++; if (ctrl !== C_ZERO) $display("[TB] FAIL sw_reset_ctrl: got %b expected %b", ctrl, C_ZERO); else passes++;
        checks++; if (addrs !== 9'd0) $display("[TB] FAIL sw_reset_addrs: got %b expected %b", addrs, 9'd0); else passes++;
        Reset = 1'b0;
        @(negedge CLK);
        checks++; if (output_state !== 4'd1) $display("[TB] FAIL sw_release_decode: got %0d expected 1", output_state); else passes++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_fetch_wait_jump();
        test_sw_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL use a single clock `CLK` and a reset `Reset`; all state is updated on the rising edge of `CLK`; `Reset` is asynchronous and active-high.
REQ-002 Port list, one per line (name, direction, width, meaning):
- CLK  in  1  clock
- Reset  in  1  async active-high reset
- input_instruction  in  16  current IR contents
- input_mem_ready  in  1  memory completes access this cycle
- input_zero  in  1  ALU zero flag
- output_PCWrite  out  1  unconditional PC write
- output_PCWriteCond  out  1  PC write if input_zero
- output_IorD  out  1  0 = PC address, 1 = ALUOut address
- output_MemRead  out  1  memory read
- output_MemWrite  out  1  memory write
- output_IRWrite  out  1  load IR
- output_reg_write  out  1  register file write enable
- output_memToReg  out  1  writeback select: 1 = MDR, 0 = ALUOut
- output_reg_readA_address  out  3  = instr[8:6]
- output_reg_readB_address  out  3  = instr[5:3]
- output_reg_write_address  out  3  = instr[11:9]
- output_ALUSrcA  out  1  0 = PC, 1 = A
- output_ALUSrcB  out  2  00 = B, 01 = const 2, 10 = imm
- output_ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 pass B
- output_PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- output_state  out  4  current state, for debug

REQ-003 Parameter: none; the opcode is instr[15:12].

Function
REQ-004 Opcodes SHALL decode as follows: 0000 add, 0001 sub, 0010 and, 0011 or (3R); 0100 addi (2RI); 0101 lui (RI); 0110 lw; 0111 sw (L); 1000 beq; 1001 j (UJ). Opcodes 1010-1111 are illegal.
REQ-005 State encoding SHALL be: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, EXEC_LUI=4, MEM_ADDR=5, MEM_READ=6, MEM_WRITE=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11. Codes 12-15 SHALL return to FETCH on the next edge.
REQ-006 Outputs SHALL be Moore, decoded from state only. Address outputs are combinational from input_instruction. Any output not listed for a state is 0.
REQ-007 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00. IRWrite and PCWrite SHALL equal input_mem_ready. The block stays in FETCH while !input_mem_ready and goes to DECODE when ready.
REQ-008 DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=add (branch target into ALUOut). Next state by opcode: 3R->EXEC_R, addi->EXEC_I, lui->EXEC_LUI, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, illegal->FETCH.
REQ-009 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=opcode[1:0] zero-extended to 3 bits; next state WB_ALU.
REQ-010 EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=add; next state WB_ALU.
REQ-011 EXEC_LUI: ALUSrcB=10, ALUOp=pass B; next state WB_ALU.
REQ-012 WB_ALU: reg_write=1, memToReg=0; next state FETCH.
REQ-013 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add; next state MEM_READ for lw, MEM_WRITE for sw.
REQ-014 MEM_READ: MemRead=1, IorD=1. The block holds until input_mem_ready, then goes to WB_MEM.
REQ-015 MEM_WRITE: MemWrite=1, IorD=1. The block holds until input_mem_ready, then goes to FETCH.
REQ-016 WB_MEM: reg_write=1, memToReg=1; next state FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01; next state FETCH. PCWrite stays 0.
REQ-018 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-019 Cycle counts SHALL be, with zero memory wait:
- 3R/addi/lui: 4 cycles
- lw: 5 cycles
- sw: 4 cycles
- beq/j: 3 cycles
- illegal: 2 cycles
Each memory wait cycle adds one cycle.
REQ-020 reg_write and MemWrite SHALL never be asserted in the same cycle. For an illegal opcode, no write of any kind (reg_write, MemWrite, PCWrite, PCWriteCond) SHALL occur.

Reset
REQ-021 While Reset=1, state SHALL be FETCH and every control output SHALL be 0. This applies even though FETCH normally asserts signals: the outputs are gated by Reset.
REQ-022 Reset asserted mid-instruction (including a MEM_WRITE wait) SHALL abort the instruction immediately, with no further writes.
REQ-023 On the first CLK edge after release, the block SHALL evaluate FETCH normally.

Verification
REQ-024 Test: reset, then mem_ready=1, instr=16'h0298 (add r1,r2,r3). Required: state sequence 0,1,2,8,0; in state 8, reg_write=1, memToReg=0, write addr=1, readA=2, readB=3.
REQ-025 Test: instr=16'h6280 (lw), mem_ready low for 2 cycles in MEM_READ. Required: MEM_READ held 3 cycles with MemRead=1, IorD=1; then WB_MEM with memToReg=1, reg_write=1.
REQ-026 Test: instr=16'h8098 (beq), input_zero=1. Required: BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=001, PCWrite=0; back to FETCH.
REQ-027 Test: instr=16'hF000. Required: DECODE->FETCH; no reg_write, MemWrite, PCWrite or PCWriteCond after the FETCH cycle.
REQ-028 Test: sw with Reset pulsed during the MEM_WRITE wait. Required: MemWrite drops in the same timestep, state reads 0, all outputs read 0 until release.
